// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: request/ready handshake with a word-addressed memory,
// byte-lane strobes, load extension, and fault reporting with a one-cycle done pulse.
module lsu_mem_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fault,
    output logic [WIDTH-1:0] load_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             is_store_q, is_store_nx;
    logic [2:0]       funct3_q, funct3_nx;
    logic [1:0]       off_q, off_nx;

    logic             busy_nx, done_nx, mem_req_nx, mem_we_nx;
    logic [1:0]       fault_nx;
    logic [WIDTH-1:0] load_data_nx, mem_addr_nx, mem_wdata_nx;
    logic [3:0]       mem_wstrb_nx;

    logic             illegal_c, misaligned_c;
    logic [WIDTH-1:0] wdata_c, shifted_c, ext_c;
    logic [3:0]       wstrb_c;

    // Request check on the incoming operation
    always_comb begin
        if (is_store) illegal_c = (funct3 > 3'b010);
        else          illegal_c = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        misaligned_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Store lane replication and strobes
    always_comb begin
        wdata_c = store_data;
        wstrb_c = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                wdata_c = {4{store_data[7:0]}};
                wstrb_c = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_c = {2{store_data[15:0]}};
                wstrb_c = 4'b0011 << addr[1:0];
            end
            default: begin
                wdata_c = store_data;
                wstrb_c = 4'b1111;
            end
        endcase
        if (!is_store) wstrb_c = 4'b0000;
    end

    // Load lane extraction and extension
    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  ext_c = {24'd0, shifted_c[7:0]};
            3'b101:  ext_c = {16'd0, shifted_c[15:0]};
            default: ext_c = shifted_c;
        endcase
    end

    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        is_store_nx  = is_store_q;
        funct3_nx    = funct3_q;
        off_nx       = off_q;
        done_nx      = 1'b0;
        fault_nx     = fault;
        load_data_nx = load_data;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        mem_wstrb_nx = mem_wstrb;

        case (state)
            S_IDLE: begin
                fault_nx = FAULT_OK;
                if (start) begin
                    is_store_nx = is_store;
                    funct3_nx   = funct3;
                    off_nx      = addr[1:0];
                    if (illegal_c) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        fault_nx = FAULT_ILLEGAL;
                    end else if (misaligned_c) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        fault_nx = FAULT_ALIGN;
                    end else begin
                        state_nx     = S_REQ;
                        wait_cnt_nx  = '0;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = is_store;
                        mem_addr_nx  = {addr[WIDTH-1:2], 2'b00};
                        mem_wdata_nx = wdata_c;
                        mem_wstrb_nx = wstrb_c;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_nx   = S_DONE;
                    done_nx    = 1'b1;
                    fault_nx   = FAULT_OK;
                    mem_req_nx = 1'b0;
                    mem_we_nx  = 1'b0;
                    if (!is_store_q) load_data_nx = ext_c;
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    state_nx   = S_DONE;
                    done_nx    = 1'b1;
                    fault_nx   = FAULT_TIMEOUT;
                    mem_req_nx = 1'b0;
                    mem_we_nx  = 1'b0;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                fault_nx = FAULT_OK;
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= FAULT_OK;
            load_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            is_store_q <= is_store_nx;
            funct3_q   <= funct3_nx;
            off_q      <= off_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            fault      <= fault_nx;
            load_data  <= load_data_nx;
            mem_req    <= mem_req_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            mem_wstrb  <= mem_wstrb_nx;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed plan cases plus randomized operations
// compared against a lane-level behavioural model.
module tb_lsu_mem_stage;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_store, mem_ready;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        busy, done, mem_req, mem_we;
    logic [1:0]  fault;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_ld = 32'd0;

    lsu_mem_stage #(.WIDTH(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done), .fault(fault),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Access size in bytes, 0 for an illegal code
    function automatic int size_of(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [1:0] m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(st, f3);
        if (sz == 0) return 2'b10;
        if ((a % sz) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rd);
        int sz = size_of(1'b0, f3);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (((rd >> (8 * (o + k))) & 32'hFF) << (8 * k));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] o);
        int sz = size_of(1'b1, f3);
        logic [3:0] s = 4'd0;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_of(1'b1, f3);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) w = w | (((sd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return w;
    endfunction

    // Drives one operation and a memory with 'waits' stall cycles; reports what it observed
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, sd, rd,
                          input int waits, input bit extra,
                          output int lat, output int reqc, output logic [1:0] f, output logic we,
                          output logic [31:0] ma, wd, output logic [3:0] ws,
                          output logic [31:0] ld, output bit unstable);
        lat = -1; reqc = 0; f = 2'b00; we = 1'b0; ma = '0; wd = '0; ws = '0;
        ld = load_data; unstable = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            start = 1'b0;
            if (done) begin
                lat = c; f = fault; ld = load_data;
                break;
            end
            if (mem_req) begin
                reqc++;
                if (reqc > 1 && (we !== mem_we || ma !== mem_addr || wd !== mem_wdata || ws !== mem_wstrb))
                    unstable = 1'b1;
                we = mem_we; ma = mem_addr; wd = mem_wdata; ws = mem_wstrb;
                if (reqc > waits) mem_ready = 1'b1;
            end
            if (extra) begin
                start = 1'b1; is_store = 1'($urandom); funct3 = 3'($urandom);
                addr = $urandom; store_data = $urandom;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, mem_req, mem_we, fault} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got busy/done/req/we/fault=%b required 000000", {busy, done, mem_req, mem_we, fault});
        end
        n_tests++;
        if ({load_data, mem_addr, mem_wdata, mem_wstrb} !== 100'b0) begin
            n_fail++; $display("FAIL reset_data: got ld=%h ma=%h wd=%h ws=%b required all zero", load_data, mem_addr, mem_wdata, mem_wstrb);
        end
        reset = 1'b0;
        exp_ld = 32'd0;
    endtask

    task automatic test_directed();
        int lat, reqc; logic [1:0] f; logic we, un; logic [31:0] ma, wd, ld; logic [3:0] ws;
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (ma !== 32'h100 || reqc != 1 || lat != 2 || ld !== 32'hDEADBEEF || f !== 2'b00) begin
            n_fail++; $display("FAIL lw_basic: got ma=%h reqc=%0d lat=%0d ld=%h f=%b required 100/1/2/deadbeef/00", ma, reqc, lat, ld, f);
        end
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (ld !== 32'hFFFFFF80 || lat != 3) begin
            n_fail++; $display("FAIL lb_sign: got ld=%h lat=%0d required ffffff80/3", ld, lat);
        end
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (ld !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_zero: got ld=%h required 00000080", ld);
        end
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (ld !== 32'h000080FF) begin
            n_fail++; $display("FAIL lhu_zero: got ld=%h required 000080ff", ld);
        end
        exp_ld = 32'h000080FF;
        run_op(1'b1, 3'b000, 32'h201, 32'hA5, 32'h0, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (we !== 1'b1 || ws !== 4'b0010 || wd !== 32'hA5A5A5A5 || ma !== 32'h200 || ld !== exp_ld) begin
            n_fail++; $display("FAIL sb_lanes: got we=%b ws=%b wd=%h ma=%h ld=%h required 1/0010/a5a5a5a5/200/%h", we, ws, wd, ma, ld, exp_ld);
        end
        run_op(1'b1, 3'b001, 32'h202, 32'h1234, 32'h0, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (ws !== 4'b1100 || wd !== 32'h12341234) begin
            n_fail++; $display("FAIL sh_lanes: got ws=%b wd=%h required 1100/12341234", ws, wd);
        end
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (lat != 1 || f !== 2'b01 || reqc != 0) begin
            n_fail++; $display("FAIL lw_misaligned: got lat=%0d f=%b reqc=%0d required 1/01/0", lat, f, reqc);
        end
        run_op(1'b1, 3'b011, 32'h203, 32'h0, 32'h0, 0, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (lat != 1 || f !== 2'b10 || reqc != 0) begin
            n_fail++; $display("FAIL st_illegal: got lat=%0d f=%b reqc=%0d required 1/10/0", lat, f, reqc);
        end
    endtask

    task automatic test_timeout();
        int lat, reqc; logic [1:0] f; logic we, un; logic [31:0] ma, wd, ld; logic [3:0] ws;
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h55555555, 100, 1'b1, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (reqc != MW || lat != MW + 1 || f !== 2'b11 || ld !== exp_ld || un) begin
            n_fail++; $display("FAIL timeout: got reqc=%0d lat=%0d f=%b ld=%h unstable=%0d required %0d/%0d/11/%h/0", reqc, lat, f, ld, un, MW, MW + 1, exp_ld);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || fault !== 2'b00) begin
            n_fail++; $display("FAIL done_pulse: got done=%b busy=%b fault=%b required 0/0/00", done, busy, fault);
        end
    endtask

    task automatic test_ready_idle();
        bit bad = 1'b0;
        mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            if (busy !== 1'b0 || done !== 1'b0 || load_data !== exp_ld) bad = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_tests++;
        if (bad || load_data !== exp_ld) begin
            n_fail++; $display("FAIL ready_idle: got ld=%h busy=%b required %h/0", load_data, busy, exp_ld);
        end
    endtask

    task automatic test_random();
        int lat, reqc, waits, e_lat, e_reqc; logic [1:0] f, ef; logic we, un, st;
        logic [31:0] ma, wd, ld, a, sd, rd; logic [3:0] ws; logic [2:0] f3;
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom); f3 = 3'($urandom); a = $urandom; sd = $urandom; rd = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            waits = $urandom_range(0, MW + 1);
            ef = m_fault(st, f3, a);
            if (ef != 2'b00) begin
                e_lat = 1; e_reqc = 0;
            end else if (waits >= MW) begin
                ef = 2'b11; e_lat = MW + 1; e_reqc = MW;
            end else begin
                e_lat = waits + 2; e_reqc = waits + 1;
                if (!st) exp_ld = m_load(f3, a[1:0], rd);
            end
            run_op(st, f3, a, sd, rd, waits, 1'($urandom), lat, reqc, f, we, ma, wd, ws, ld, un);
            n_tests++;
            if (lat != e_lat || reqc != e_reqc || f !== ef || ld !== exp_ld || un) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d]: got lat=%0d reqc=%0d f=%b ld=%h un=%0d required %0d/%0d/%b/%h/0", n, lat, reqc, f, ld, un, e_lat, e_reqc, ef, exp_ld);
            end
            if (e_reqc > 0) begin
                n_tests++;
                if (ma !== {a[31:2], 2'b00} || we !== st || ws !== (st ? m_wstrb(f3, a[1:0]) : 4'b0000) ||
                    (st && wd !== m_wdata(f3, sd))) begin
                    n_fail++; $display("FAIL rnd_bus[%0d]: got ma=%h we=%b ws=%b wd=%h for st=%b f3=%b a=%h sd=%h", n, ma, we, ws, wd, st, f3, a, sd);
                end
            end
        end
    endtask

    task automatic test_reset_mid_req();
        int lat, reqc; logic [1:0] f; logic we, un; logic [31:0] ma, wd, ld, rd; logic [3:0] ws;
        bit saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL mid_req_setup: got mem_req=%b required 1", mem_req);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: got mem_req=%b busy=%b required 0/0", mem_req, busy);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        mem_ready = 1'b0;
        reset = 1'b0;
        exp_ld = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++; $display("FAIL reset_no_done: got done pulse required none");
        end
        rd = $urandom;
        run_op(1'b0, 3'b010, 32'h0, 32'h0, rd, 1, 1'b0, lat, reqc, f, we, ma, wd, ws, ld, un);
        n_tests++;
        if (lat != 3 || f !== 2'b00 || ld !== rd || ma !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_lw: got lat=%0d f=%b ld=%h ma=%h required 3/00/%h/0", lat, f, ld, ma, rd);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_timeout();
        test_ready_idle();
        test_random();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address for RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Runs a request/ready handshake with a word-addressed data memory, applies byte-lane strobes and load sign/zero extension.
- Reports misalignment, illegal funct3 and memory timeout as a fault code alongside a one-cycle done pulse.

Parameters:
WIDTH, 32, data/address width; only 32 supported (4 byte lanes)
MAX_WAIT, 255, max cycles in REQ without mem_ready before timeout abort (1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
is_store  input  1  1 = store, 0 = load
funct3  input  3  RV32I load/store width/sign code
addr  input  WIDTH  effective address (ALU alu_out)
store_data  input  WIDTH  rs2 value for stores
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
fault  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done
load_data  output  WIDTH  extended load result
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  write enable
mem_addr  output  WIDTH  word address {addr[31:2],2'b00}
mem_wdata  output  WIDTH  lane-replicated store data
mem_wstrb  output  4  byte-lane strobes
mem_ready  input  1  memory accept/complete, single cycle
mem_rdata  input  WIDTH  read data, valid with mem_ready

Behaviour:
- Reset (async, immediate): state IDLE; busy, done, mem_req, mem_we = 0; fault = 00; load_data, mem_addr, mem_wdata = 0; mem_wstrb = 0; wait counter = 0.
- States: IDLE, REQ, DONE.
- IDLE, start=1: latch is_store, funct3, addr[1:0], store_data; compute the check.
  - Illegal funct3 → DONE with fault=10.
    - Loads: 011, 110, 111 are illegal.
    - Stores: anything other than 000, 001, 010 is illegal.
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0) → DONE with fault=01.
  - Illegal funct3 takes priority over misaligned.
  - Otherwise → REQ.
  - A faulting request never asserts mem_req.
- REQ:
  - mem_req=1; mem_we=is_store; mem_addr, mem_wdata, mem_wstrb stable for the whole state.
  - Loads drive mem_wstrb=0000.
  - mem_ready=1 → DONE with fault=00. On a load, load_data is updated in the same edge.
  - No mem_ready: wait counter increments each cycle. Counter reaching MAX_WAIT → DONE with fault=11, mem_req dropped.
- DONE: done=1 for exactly one cycle, fault held for that cycle, then → IDLE. fault returns to 00 in IDLE.
- Latency:
  - Zero-wait memory (mem_ready in first REQ cycle): done two cycles after the start edge.
  - Each wait cycle adds one.
  - Faulting request: done one cycle after start.
- start while busy is ignored (not queued). Back-to-back: start accepted in the IDLE cycle following DONE.
- Store lanes, with o = addr[1:0]:
  - SB: mem_wdata = byte replicated ×4, mem_wstrb = 0001 << o.
  - SH: mem_wdata = halfword replicated ×2, mem_wstrb = 0011 << o.
  - SW: mem_wstrb = 1111.
- Load extract: x = mem_rdata >> (8*o).
  - LB: sign-extend x[7:0]. LBU: zero-extend x[7:0].
  - LH: sign-extend x[15:0]. LHU: zero-extend x[15:0].
  - LW: x.
- load_data changes only on a successful load completion. It holds through stores, faults and idle.
- mem_ready outside REQ is ignored.
- Reset during REQ drops mem_req immediately. No done is produced for the aborted request.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, zero wait → mem_addr=0x100, mem_req one cycle, done two cycles after start, load_data=0xDEADBEEF, fault=00.
- LB, addr=0x103, mem_rdata=0x80FF1234 → load_data=0xFFFFFF80. LBU same access → 0x00000080. LHU addr=0x102 → 0x000080FF.
- SB, addr=0x201, store_data=0x000000A5 → mem_we=1, mem_wstrb=0010, mem_wdata=0xA5A5A5A5, mem_addr=0x200. SH, addr=0x202, store_data=0x1234 → wstrb=1100, wdata=0x12341234.
- LW, addr=0x102 → done one cycle after start, fault=01, mem_req never high. Store with funct3=011 → fault=10, illegal taking priority even if misaligned.
- mem_ready withheld, MAX_WAIT=4 → mem_req high 4 cycles, then done with fault=11, load_data unchanged. Extra start pulses during busy are ignored.
- Reset asserted mid-REQ → mem_req, busy drop immediately, no done pulse. After release, an LW at 0x0 completes normally.
